acq_mem_tx: RTL and testbench

//  Read-out side of the acquisition buffers: on a start pulse, reads mask/APD0/APD1 BRAM words
//  at addresses 0..data_points-1 through the shared read address. Serialises them as a framed

---
 rtl/acq_mem_tx_pkg.sv | 28 ++
 rtl/acq_mem_tx_if.sv | 9 +
 rtl/acq_mem_tx_byte_shift_tx.sv | 62 ++++++
 rtl/acq_mem_tx.sv | 141 ++++++++++++++
 tb/tb_acq_mem_tx.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/acq_mem_tx_pkg.sv
// Shared constants, payload layout and FSM encoding for the acquisition read-out path.
package acq_mem_tx_pkg;

  localparam logic [7:0]  SYNC0_DEF       = 8'hA5;
  localparam logic [7:0]  SYNC1_DEF       = 8'h5A;
  localparam int unsigned BYTES_PER_POINT = 10;
  localparam int unsigned CNT_W           = 4;

  typedef struct packed {
    logic [15:0] mask;
    logic [31:0] apd0;
    logic [31:0] apd1;
  } point_t;

  localparam int unsigned WORD_W = $bits(point_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RADDR,
    ST_RWAIT,
    ST_LOAD,
    ST_SEND,
    ST_CSUM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/acq_mem_tx_if.sv
// Byte stream from the read-out engine to the UART transmitter (valid/ready).
interface acq_mem_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/acq_mem_tx_byte_shift_tx.sv
// Loads a chunk of up to 10 bytes, shifts it out MSB-first over valid/ready and
// accumulates the frame checksum over bytes at or beyond the chunk's skip index.
module acq_mem_tx_byte_shift_tx
  import acq_mem_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [CNT_W-1:0]  skip_i,
  output logic [7:0]        csum_o,
  output logic              last_c,
  acq_mem_tx_if.master      tx
);

  logic [WORD_W-1:0] shift_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  skip_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              valid_q;
  logic [7:0]        csum_q;
  logic              fire_c;

  assign fire_c      = valid_q & tx.tx_ready;
  assign last_c      = fire_c && (cnt_q == (len_q - CNT_W'(1)));
  assign tx.tx_valid = valid_q;
  assign tx.tx_data  = shift_q[WORD_W-1 -: 8];
  assign csum_o      = csum_q;

  // Shifted-out positions fill with zero, so tx_data returns to 0 once a chunk drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      len_q   <= '0;
      skip_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      csum_q  <= '0;
    end else begin
      if (clr_i) begin
        csum_q <= '0;
      end else if (fire_c && (cnt_q >= skip_q)) begin
        csum_q <= csum_q + shift_q[WORD_W-1 -: 8];
      end

      if (load_i) begin
        shift_q <= word_i;
        len_q   <= len_i;
        skip_q  <= skip_i;
        cnt_q   <= '0;
        valid_q <= 1'b1;
      end else if (fire_c) begin
        shift_q <= {shift_q[WORD_W-9:0], 8'h00};
        cnt_q   <= cnt_q + CNT_W'(1);
        if (last_c) valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/acq_mem_tx.sv
// Acquisition buffer read-out: reads mask/APD0/APD1 words 0..N-1 and streams them
// as a framed, checksummed byte sequence, then pulses ready_tx.
module acq_mem_tx
  import acq_mem_tx_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned RD_LAT = 1,
  parameter logic [7:0]  SYNC0  = SYNC0_DEF,
  parameter logic [7:0]  SYNC1  = SYNC1_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_tx,
  input  logic [15:0]       data_points,
  output logic [ADDR_W-1:0] addr_rd,
  input  logic [15:0]       din0,
  input  logic [31:0]       din1,
  input  logic [31:0]       din2,
  output logic              ready_tx,
  output logic              busy,
  acq_mem_tx_if.master      tx
);

  localparam int unsigned IDX_W  = ADDR_W + 1;
  localparam int unsigned WAIT_W = 2;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  state_e            state_q;
  logic [IDX_W-1:0]  n_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WAIT_W-1:0] wait_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ready_q;
  logic              busy_q;

  logic [IDX_W-1:0]  n_start_c;
  logic              ld_c;
  logic              clr_c;
  logic [WORD_W-1:0] word_c;
  logic [CNT_W-1:0]  len_c;
  logic [CNT_W-1:0]  skip_c;
  logic [7:0]        csum;
  logic              last_c;
  point_t            pt_c;

  assign n_start_c = (17'(data_points) > 17'(DEPTH)) ? IDX_W'(DEPTH) : IDX_W'(data_points);
  assign pt_c      = '{mask: din0, apd0: din1, apd1: din2};
  assign addr_rd   = addr_q;
  assign ready_tx  = ready_q;
  assign busy      = busy_q;

  // Chunk loads: header on accepted start, point word in LOAD, checksum once the stage drains.
  always_comb begin
    ld_c   = 1'b0;
    clr_c  = 1'b0;
    word_c = '0;
    len_c  = '0;
    skip_c = '0;
    case (state_q)
      ST_IDLE: if (start_tx) begin
        ld_c   = 1'b1;
        clr_c  = 1'b1;
        word_c = {SYNC0, SYNC1, 16'(n_start_c), 48'h0};
        len_c  = CNT_W'(4);
        skip_c = CNT_W'(2);
      end
      ST_LOAD: begin
        ld_c   = 1'b1;
        word_c = pt_c;
        len_c  = CNT_W'(BYTES_PER_POINT);
      end
      ST_CSUM: if (!tx.tx_valid) begin
        ld_c   = 1'b1;
        word_c = {csum, 72'h0};
        len_c  = CNT_W'(1);
        skip_c = CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_tx) begin
          n_q     <= n_start_c;
          idx_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= ST_HDR;
        end
        ST_HDR: if (last_c) state_q <= (n_q == '0) ? ST_CSUM : ST_RADDR;
        ST_RADDR: begin
          addr_q  <= idx_q[ADDR_W-1:0];
          wait_q  <= '0;
          state_q <= ST_RWAIT;
        end
        ST_RWAIT: begin
          if (wait_q == WAIT_W'(RD_LAT - 1)) state_q <= ST_LOAD;
          else                               wait_q  <= wait_q + WAIT_W'(1);
        end
        ST_LOAD: state_q <= ST_SEND;
        ST_SEND: if (last_c) begin
          idx_q   <= idx_q + IDX_W'(1);
          state_q <= ((idx_q + IDX_W'(1)) == n_q) ? ST_CSUM : ST_RADDR;
        end
        ST_CSUM: if (last_c) begin
          ready_q <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  acq_mem_tx_byte_shift_tx u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr_c),
    .load_i (ld_c),
    .word_i (word_c),
    .len_i  (len_c),
    .skip_i (skip_c),
    .csum_o (csum),
    .last_c (last_c),
    .tx     (tx)
  );

endmodule

// File: tb/tb_acq_mem_tx.sv
// Directed bench for acq_mem_tx: BRAM model with 2-cycle latency, byte collector,
// frame reference model and hand-computed checksums.
module tb_acq_mem_tx;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 2;

  logic          clk;
  logic          rst_n;
  logic          start_tx;
  logic [15:0]   data_points;
  logic [AW-1:0] addr_rd;
  logic [15:0]   din0;
  logic [31:0]   din1;
  logic [31:0]   din2;
  logic          ready_tx;
  logic          busy;

  acq_mem_tx_if tx_if ();

  acq_mem_tx #(.ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_tx    (start_tx),
    .data_points (data_points),
    .addr_rd     (addr_rd),
    .din0        (din0),
    .din1        (din1),
    .din2        (din2),
    .ready_tx    (ready_tx),
    .busy        (busy),
    .tx          (tx_if)
  );

  logic [79:0] mem [1024];
  logic [79:0] rd1, rd2;

  always @(posedge clk) begin
    rd1 <= mem[addr_rd];
    rd2 <= rd1;
  end
  assign din0 = rd2[79:64];
  assign din1 = rd2[63:32];
  assign din2 = rd2[31:0];

  int         n_vec = 0;
  int         n_miss = 0;
  int         cyc = 0;
  int         duty = 100;
  int         ready_cnt = 0;
  int         ready_cyc = 0;
  int         last_fire_cyc = 0;
  int         stall_err = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_exp(input int n);
    logic [7:0]  s;
    logic [79:0] w;
    logic [15:0] nn;
    nn = 16'(n);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(nn[15:8]);
    exp_q.push_back(nn[7:0]);
    s = nn[15:8] + nn[7:0];
    for (int i = 0; i < n; i++) begin
      w = mem[i];
      for (int b = 0; b < 10; b++) begin
        exp_q.push_back(w[79-8*b -: 8]);
        s = s + w[79-8*b -: 8];
      end
    end
    exp_q.push_back(s);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tx_if.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_if.tx_ready = ($urandom_range(99) < duty);
    end
  end

  // Byte collector, stall-stability watch and ready_tx pulse tracking.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== prev_data)) stall_err++;
        if (tx_if.tx_valid && tx_if.tx_ready) begin
          rx_q.push_back(tx_if.tx_data);
          last_fire_cyc = cyc;
        end
        if (ready_tx) begin
          ready_cnt++;
          ready_cyc = cyc;
        end
        prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
        prev_data  = tx_if.tx_data;
      end
    end
  end

  task automatic run_frame(input logic [15:0] dp, input int n, input int dty, input int dup,
                           input logic [7:0] csum_exp);
    int nbad;
    int lim;
    nbad = 0;
    build_exp(n);
    rx_q.delete();
    ready_cnt = 0;
    stall_err = 0;
    duty      = dty;
    @(posedge clk); #1;
    start_tx    = 1'b1;
    data_points = dp;
    @(posedge clk); #1;
    start_tx    = 1'b0;
    chk("busy_on", busy, 1);
    chk("rdy_early", ready_tx, 0);
    if (dup > 0) begin
      repeat (dup) @(posedge clk);
      #1;
      start_tx    = 1'b1;
      data_points = 16'd5;
      @(posedge clk); #1;
      start_tx    = 1'b0;
    end
    for (int k = 0; k < 40 * n + 300 && ready_cnt == 0; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk("done_seen", 32'(ready_cnt != 0), 1);
    chk("len", rx_q.size(), exp_q.size());
    lim = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) if (rx_q[i] !== exp_q[i]) nbad++;
    chk("bytes", nbad, 0);
    if (rx_q.size() > 0) chk("csum", rx_q[$], csum_exp);
    chk("rdy_cnt", ready_cnt, 1);
    chk("rdy_lat", ready_cyc - last_fire_cyc, 1);
    chk("busy_off", busy, 0);
    chk("stall", stall_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = {16'(i), 32'h1000_0000 | 32'(i), 32'h2000_0000 | 32'(i)};
    rst_n       = 1'b0;
    start_tx    = 1'b0;
    data_points = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", tx_if.tx_valid, 0);
    chk("rst_data", tx_if.tx_data, 0);
    chk("rst_addr", addr_rd, 0);
    chk("rst_ready", ready_tx, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Empty frame: A5 5A 00 00 00
    run_frame(16'd0, 0, 100, 0, 8'h00);
    chk("n0_addr", addr_rd, 0);

    // Three points, full rate
    run_frame(16'd3, 3, 100, 0, 8'h9C);
    chk("n3_addr", addr_rd, 2);

    // Two points with a throttled UART
    run_frame(16'd2, 2, 30, 0, 8'h65);

    // Count clamps to buffer depth
    run_frame(16'hFFFF, 1024, 100, 0, 8'h04);
    if (rx_q.size() > 3) begin
      chk("cnt_hi", rx_q[2], 8'h04);
      chk("cnt_lo", rx_q[3], 8'h00);
    end
    chk("last_addr", addr_rd, 10'h3FF);

    // Reset while point 1 is being sent
    rx_q.delete();
    ready_cnt = 0;
    duty      = 100;
    @(posedge clk); #1;
    start_tx    = 1'b1;
    data_points = 16'd3;
    @(posedge clk); #1;
    start_tx    = 1'b0;
    for (int k = 0; k < 500 && rx_q.size() < 17; k++) @(negedge clk);
    chk("mid_reached", 32'(rx_q.size() >= 17), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", tx_if.tx_valid, 0);
    chk("mid_data", tx_if.tx_data, 0);
    chk("mid_busy", busy, 0);
    chk("mid_addr", addr_rd, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_no_rdy", ready_cnt, 0);
    run_frame(16'd1, 1, 100, 0, 8'h31);

    // Second start while busy is ignored
    run_frame(16'd2, 2, 100, 5, 8'h65);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
